booth_seq_mul: RTL

- Multi-cycle signed multiplier controller for the radix-2 Booth shift/add step (A/M/Q with appended Q[-1] bit).
- Accepts one operand pair through a valid/ready handshake and applies exactly one Booth step per clock for WIDTH clocks.
- Presents the 2*WIDTH-bit signed product through a valid/ready handshake and holds it until consumed.
- Sits between the operand source (register file / ALU issue) and the result writeback.

---
 rtl/booth_seq_mul.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
//   Sequential signed multiplier. Applies one radix-2 Booth step per clock
//   (A/M/Q with the appended Q[-1] bit) and takes WIDTH clocks per product.
//   Operands are accepted through a valid/ready handshake. The product is
//   returned through a second valid/ready handshake and is held until the
//   consumer takes it.
//
// Ports
//   clk           system clock, rising-edge
//   rst           synchronous, active-high reset
//   in_valid      operand pair present
//   in_ready      block can accept an operand pair (IDLE)
//   multiplicand  signed M, WIDTH bits
//   multiplier    signed Q, WIDTH bits
//   out_valid     product valid (DONE)
//   out_ready     consumer accepts product
//   product       signed M*Q, 2*WIDTH bits, registered
//   busy          high in RUN or DONE
// -----------------------------------------------------------------------------
module booth_seq_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // A carries one guard bit so that A-M cannot overflow, even for
  // M = most-negative value.
  logic [WIDTH:0]       a_reg, a_sum, a_next;
  logic [WIDTH:0]       q_reg, q_next;   // q_reg[0] is Q[-1]
  logic [WIDTH:0]       m_reg;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_reg;

  logic accept;
  logic last_step;
  logic cnt_bad;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  // Defensive: unreachable counter values send the FSM home.
  assign cnt_bad   = (32'(cnt) >= WIDTH);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN: begin
        if (cnt_bad)        state_next = ST_IDLE;
        else if (last_step) state_next = ST_DONE;
      end
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign product = product_reg;

  // ---------------------------------------------------------------------------
  // Booth step: conditional add/subtract on {Q[0],Q[-1]}, then an arithmetic
  // right shift of {A,Q}; A's LSB moves into Q's MSB.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sum = a_reg;
    case (q_reg[1:0])
      2'b01:   a_sum = a_reg + m_reg;
      2'b10:   a_sum = a_reg + ~m_reg + {{WIDTH{1'b0}}, 1'b1};
      default: ;
    endcase
    {a_next, q_next} = {a_sum[WIDTH], a_sum, q_reg[WIDTH:1]};
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg <= '0;
            q_reg <= {multiplier, 1'b0};
            m_reg <= {multiplicand[WIDTH-1], multiplicand};
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (!cnt_bad) begin
            a_reg <= a_next;
            q_reg <= q_next;
            cnt   <= cnt + CNT_W'(1);
            // Capture the finished product on the final step so it is
            // registered and stable for all of DONE and afterwards.
            if (last_step)
              product_reg <= {a_next[WIDTH-1:0], q_next[WIDTH:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
